// File: rtl/fan_pkg.sv
// Shared constants and elaboration helpers for the battery-fan controller.
// Latency: none (package only).
// Backpressure: none.
package fan_pkg;

  // Default rates, in milliseconds per step
  localparam int DEF_N_GEARS      = 4;
  localparam int DEF_BATT_MAX     = 99;
  localparam int DEF_CHG_IDLE_MS  = 100;
  localparam int DEF_CHG_RUN_MS   = 200;
  localparam int DEF_DIS_BASE_MS  = 800;
  localparam int DEF_ANIM_BASE_MS = 1000;
  localparam int DEF_FRAME_W      = 2;
  localparam int DEF_LOW_THRESH   = 20;

  // Gear index of the idle (fan off) state
  localparam int GEAR_IDLE = 0;

  // Width of the gear index; a two-gear fan still needs one bit
  function automatic int gear_width(input int n_gears);
    return (n_gears <= 2) ? 1 : $clog2(n_gears);
  endfunction

  // Interval for gear g: base for gear 1, halved per gear above it, never below 1 ms
  function automatic int shift_interval(input int base_ms, input int gear);
    int v;
    v = (gear <= 1) ? base_ms : (base_ms >> (gear - 1));
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fan_interval_cnt.sv
// Millisecond interval counter with clear/enable and a runtime-selected period.
// Latency: expire_o is combinational on the tick that completes the period; count updates next edge.
// Backpressure: none; clear and disable hold the count at 0.
module fan_interval_cnt #(
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic          tick_i,
  input  logic [CW-1:0] interval_i,
  output logic          expire_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Expiry uses the interval in force this cycle, independent of a pending clear
  assign expire_o = en_i && tick_i && (cnt_q == interval_i - CW'(1));

  // Next count: clear/disable win, then wrap on expiry, else advance per tick
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (expire_o) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fan_gear_ctrl.sv
// Battery-fan core: gear FSM, battery level with charge/discharge rates, gear-scaled animation frame.
// Latency: press -> gear +1 cycle; battery step +1 cycle after expiring tick, derived flags +2 cycles.
// Backpressure: none; FAN_LOW_BATT_EN enables the low-battery flag and gear cap.
module fan_gear_ctrl
  import fan_pkg::*;
#(
  parameter int N_GEARS      = DEF_N_GEARS,
  parameter int BATT_MAX     = DEF_BATT_MAX,
  parameter int CHG_IDLE_MS  = DEF_CHG_IDLE_MS,
  parameter int CHG_RUN_MS   = DEF_CHG_RUN_MS,
  parameter int DIS_BASE_MS  = DEF_DIS_BASE_MS,
  parameter int ANIM_BASE_MS = DEF_ANIM_BASE_MS,
  parameter int FRAME_W      = DEF_FRAME_W,
  parameter int LOW_THRESH   = DEF_LOW_THRESH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              tick_ms,
  input  logic                              btn_press,
  input  logic                              charge_en,
  output logic [gear_width(N_GEARS)-1:0]    gear,
  output logic [$clog2(BATT_MAX+1)-1:0]     battery,
  output logic                              charging,
  output logic                              batt_empty,
  output logic [FRAME_W-1:0]                frame,
  output logic                              low_batt
);

  localparam int GW = gear_width(N_GEARS);
  localparam int BW = $clog2(BATT_MAX + 1);
  localparam int CW = $clog2(max2(max2(DIS_BASE_MS, ANIM_BASE_MS),
                                  max2(CHG_IDLE_MS, CHG_RUN_MS)) + 1);

`ifdef FAN_LOW_BATT_EN
  localparam bit LOW_EN = 1'b1;
`else
  localparam bit LOW_EN = 1'b0;
`endif

  logic [GW-1:0]      gear_q, gear_d, nxt_gear;
  logic [BW-1:0]      battery_q, battery_d;
  logic               charging_q, charging_d;
  logic               empty_q, empty_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               low_q, low_d;

  logic [CW-1:0]      dis_tab  [N_GEARS];
  logic [CW-1:0]      anim_tab [N_GEARS];
  logic [CW-1:0]      bat_ival;
  logic               bat_en, bat_clr, bat_exp;
  logic               anim_en, anim_clr, anim_exp;

  // Per-gear intervals are constants folded at elaboration
  for (genvar g = 0; g < N_GEARS; g++) begin : g_ival
    assign dis_tab[g]  = CW'(shift_interval(DIS_BASE_MS, g));
    assign anim_tab[g] = CW'(shift_interval(ANIM_BASE_MS, g));
  end

  // Gear FSM: empty force, then low-battery cap, then button advance
  always_comb begin
    nxt_gear = (gear_q == GW'(N_GEARS - 1)) ? GW'(GEAR_IDLE) : gear_q + GW'(1);
    gear_d   = gear_q;
    if (empty_q && gear_q != GW'(GEAR_IDLE)) begin
      gear_d = GW'(GEAR_IDLE);
    end else if (low_q && gear_q > GW'(1)) begin
      gear_d = GW'(1);
    end else if (btn_press && battery_q != '0) begin
      gear_d = (low_q && gear_q == GW'(1)) ? GW'(GEAR_IDLE) : nxt_gear;
    end
  end

  // Status flags track the registered battery level
  always_comb begin
    charging_d = charge_en && (battery_q < BW'(BATT_MAX));
    empty_d    = (battery_q == '0);
    low_d      = LOW_EN && (battery_q < BW'(LOW_THRESH));
  end

  // Battery interval: charge rate by gear while charging, else gear discharge rate
  always_comb begin
    bat_ival = dis_tab[gear_q];
    if (charging_q) begin
      bat_ival = (gear_q == GW'(GEAR_IDLE)) ? CW'(CHG_IDLE_MS) : CW'(CHG_RUN_MS);
    end
  end

  // Any mode change restarts the interval; idle gear without charge holds it at 0
  assign bat_en   = charging_q || (gear_q != GW'(GEAR_IDLE));
  assign bat_clr  = (gear_d != gear_q) || (charging_d != charging_q);
  assign anim_en  = (gear_q != GW'(GEAR_IDLE));
  assign anim_clr = (gear_d != gear_q);

  fan_interval_cnt #(.CW(CW)) u_bat_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (bat_clr),
    .en_i       (bat_en),
    .tick_i     (tick_ms),
    .interval_i (bat_ival),
    .expire_o   (bat_exp)
  );

  fan_interval_cnt #(.CW(CW)) u_anim_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (anim_clr),
    .en_i       (anim_en),
    .tick_i     (tick_ms),
    .interval_i (anim_tab[gear_q]),
    .expire_o   (anim_exp)
  );

  // Battery step on expiry, saturating at both ends
  always_comb begin
    battery_d = battery_q;
    if (bat_exp) begin
      if (charging_q) begin
        if (battery_q < BW'(BATT_MAX)) battery_d = battery_q + BW'(1);
      end else if (gear_q != GW'(GEAR_IDLE) && battery_q != '0) begin
        battery_d = battery_q - BW'(1);
      end
    end
  end

  // Animation frame: forced 0 in idle gear, otherwise advances and wraps on expiry
  always_comb begin
    frame_d = frame_q;
    if (gear_q == GW'(GEAR_IDLE)) begin
      frame_d = '0;
    end else if (anim_exp) begin
      frame_d = frame_q + FRAME_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gear_q     <= GW'(GEAR_IDLE);
      battery_q  <= BW'(BATT_MAX);
      charging_q <= 1'b0;
      empty_q    <= 1'b0;
      frame_q    <= '0;
      low_q      <= 1'b0;
    end else begin
      gear_q     <= gear_d;
      battery_q  <= battery_d;
      charging_q <= charging_d;
      empty_q    <= empty_d;
      frame_q    <= frame_d;
      low_q      <= low_d;
    end
  end

  assign gear       = gear_q;
  assign battery    = battery_q;
  assign charging   = charging_q;
  assign batt_empty = empty_q;
  assign frame      = frame_q;
  assign low_batt   = low_q;

endmodule

// File: doc/fan_gear_ctrl.md
# fan_gear_ctrl

Parametrised battery-fan controller core: an N-gear speed state machine, battery level counter with gear-dependent discharge and mode-dependent charge rates, and a gear-scaled animation frame counter for the dot-matrix driver. Sits between the shared ms-tick timer and button debouncer (inputs) and the display/LED drivers (outputs). It replaces the fixed 4-gear, 99-unit controller with a generic, fully registered core.

## Interface
- N_GEARS, 4: gear count including idle gear 0; ≥2.
- BATT_MAX, 99: full battery level; reset value.
- CHG_IDLE_MS, 100: ms per +1 while charging in gear 0.
- CHG_RUN_MS, 200: ms per +1 while charging in gear ≥1.
- DIS_BASE_MS, 800: ms per −1 in gear 1; gear g uses DIS_BASE_MS >> (g−1).
- ANIM_BASE_MS, 1000: ms per frame in gear 1; gear g uses ANIM_BASE_MS >> (g−1).
- FRAME_W, 2: frame index width.
- LOW_THRESH, 20: low-battery threshold (used only with FAN_LOW_BATT_EN).
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- tick_ms  in  1  one-cycle strobe every 1 ms.
- btn_press  in  1  debounced one-cycle gear-advance pulse.
- charge_en  in  1  charger switch, level.
- gear  out  GW=$clog2(N_GEARS)  current gear, 0 = idle.
- battery  out  BW=$clog2(BATT_MAX+1)  level 0..BATT_MAX.
- charging  out  1  charge active.
- batt_empty  out  1  battery == 0.
- frame  out  FRAME_W  animation frame index.
- low_batt  out  1  low-battery flag (0 without macro).

## Operation
- All outputs registered. Reset values: gear 0, battery BATT_MAX, charging 0, batt_empty 0, frame 0, low_batt 0; both interval counters 0.
- Gear FSM (states 0..N_GEARS−1): btn_press → gear+1, wrap N_GEARS−1 → 0. Press ignored while battery == 0.
- Empty force: battery == 0 with gear ≠ 0 → gear 0 next cycle; has priority over btn_press.
- charging = charge_en && battery < BATT_MAX (registered); goes 0 when battery reaches BATT_MAX.
- Battery counter: ms counter advances on tick_ms. Interval = CHG_IDLE_MS / CHG_RUN_MS while charging, DIS_BASE_MS>>(gear−1) while !charging && gear ≠ 0; idle otherwise (counter held 0). On tick_ms with counter == interval−1: counter → 0, battery ±1.
- Battery saturates: never above BATT_MAX, never below 0.
- Mode change (gear change, charging toggle) clears the battery counter the same cycle; new interval starts from 0.
- Full + charge_en + gear ≠ 0: charging 0, discharge resumes; charging re-asserts at BATT_MAX−1 (defined oscillation).
- Animation: separate ms counter, interval ANIM_BASE_MS>>(gear−1); on expiry frame+1, wraps 2^FRAME_W−1 → 0. Gear 0: frame and counter held 0. Gear change clears counter, frame keeps value.
- Widths: shifted intervals computed at elaboration; counters sized for DIS_BASE_MS/ANIM_BASE_MS/CHG maxima.

## Timing
- btn_press at cycle t → gear at t+1.
- tick_ms at t with counter == interval−1 → battery at t+1; charging/batt_empty/low_batt at t+2.
- batt_empty high at t → gear 0 at t+1.
- rst at any cycle overrides all events; mid-interval counts discarded.
- Simultaneous btn_press and tick expiry: both applied; battery step uses pre-press interval, counter then cleared.

## Configuration
- FAN_LOW_BATT_EN defined: low_batt = battery < LOW_THRESH (registered); while low_batt, gears >1 forced to 1 next cycle, and press from gear 1 wraps to 0.
- Not defined: low_batt tied 0, no gear cap, LOW_THRESH unused.

## Structure
- Package fan_pkg: gear width function, gear-index constants (GEAR_IDLE), interval-shift function, default rate constants.
- Sub-module fan_interval_cnt: ms counter with clear, enable, runtime interval input, one-cycle expire output; instantiated twice (battery, animation).

## Test plan
- Reset, 4 btn_press pulses → gear 1,2,3,0; frame stays 0 in gear 0.
- Gear 1, charge_en 0, 1600 ticks → battery 99→97; gear 3 → one decrement per 200 ticks.
- Battery 1, gear 2, discharge to 0 → batt_empty 1, gear 0 next cycle; further presses ignored.
- Battery 50, gear 0, charge_en 1, 300 ticks → 53; gear 1 → +1 per 200 ticks; at 99 charging drops.
- Gear 2 animation → frame increments every 500 ticks, wraps 3→0; press mid-interval restarts period.
- FAN_LOW_BATT_EN: battery 19 in gear 3 → low_batt 1, gear 1; press → gear 0; without macro gear stays 3.
